spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Parametrised SPI master that replaces the fixed single-device serial interface between the core's load/store path and external devices. It adds a programmable SCLK divider, all four CPOL/CPHA modes, N one-hot active-low chip selects and full-duplex transfers with an optional address field. One transfer carries either DATA_W bits or DATA_W+ADDR_W bits. The block sits between the datapath (`data`/`addr` registers) and the chip pins.

## Interface
- `DATA_W`, default `DATAPATH_W`: data field width.
- `ADDR_W`, default `CLOG2(DMEM_SZ)`: address field width.
- `N_CS`, default 2: number of chip selects.
- `DIV_W`, default 4: width of the divider setting.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `start_in` in 1: request a transfer; accepted only in IDLE.
- `addr_en_in` in 1: 1 means the frame is {data, addr}; 0 means data only.
- `cpol_in`, `cpha_in` in 1 each: SPI mode.
- `clk_div_in` in DIV_W: half-period H = clk_div_in+1 clk cycles.
- `cs_sel_in` in CLOG2(N_CS): target device.
- `tx_data_in` in DATA_W; `tx_addr_in` in ADDR_W: outgoing fields.
- `busy_out` out 1: a transfer is in progress.
- `done_out` out 1: one-cycle pulse at the end of a transfer.
- `rx_data_out` out DATA_W: the last DATA_W bits sampled from MISO.
- `sclk_out` out 1; `mosi_out` out 1; `miso_in` in 1; `cs_n_out` out N_CS.

## Operation
- **FSM states:** IDLE → SETUP → XFER → HOLD → IDLE.
- **IDLE → SETUP:** on `start_in`. All inputs are latched on that edge and are ignored afterwards until IDLE.
- **NBITS:** DATA_W+ADDR_W if `addr_en` is set, else DATA_W. Bits go out MSB first, data field before address field.
- **SETUP (H cycles):**
  - The selected `cs_n` bit is driven low.
  - `sclk` stays at CPOL.
  - With CPHA=0, the first bit is already on MOSI.
- **XFER (2·H·NBITS cycles):** `sclk` toggles every H cycles, giving 2·NBITS edges.
  - CPHA=0: sample MISO on the leading edge; shift MOSI on the trailing edge.
  - CPHA=1: shift MOSI on the leading edge; sample MISO on the trailing edge.
- **HOLD (H cycles):** `sclk` is at CPOL and CS is still asserted. `done_out` is high in the last HOLD cycle. CS is deasserted on entry to IDLE.
- **`rx_data_out`:** a DATA_W shift register, updated only at sample points. It holds its value until the next sample point.
- **`busy_out`:** high in SETUP, XFER and HOLD.
- **`cs_sel` ≥ N_CS:** no CS is asserted. The transfer still runs and `done_out` still pulses.
- **`start_in` while busy, including the `done_out` cycle:** ignored and not queued.
- **Bit counter:** CLOG2(DATA_W+ADDR_W+1) bits wide, loaded with NBITS, decremented per shift. No wrap.
- **Divider counter:** DIV_W bits. It reloads `clk_div` at each edge strobe. H=1 (div 0) is legal.

## Timing
- **Reset values (`rst` low at posedge):**
  - State IDLE.
  - `cs_n_out` all 1.
  - `sclk_out` 0.
  - `mosi_out` 0.
  - `busy_out`, `done_out` 0.
  - `rx_data_out` 0.
- **Reset mid-transfer:** the transfer aborts and all outputs take reset values on the same edge. No `done_out`.
- **Latency:** `start_in` is sampled at edge t. `busy_out` rises at t+1 and stays high for H·(2·NBITS+2) cycles. `done_out` is high in the final cycle of that window.
- **Registered outputs:** all outputs are registered. `sclk_out` is never the raw `clk`.
- **Idle level:** after reset, `sclk_out` idles at 0. After a transfer it idles at the latched CPOL.
- **MOSI stability:** MOSI changes only on a shift strobe, so it is stable for H cycles around every sample edge.

## Structure
- **Package `spi_pkg`:** state encoding (IDLE=0, SETUP=1, XFER=2, HOLD=3) and the CPOL/CPHA mode constants. The package reuses the existing `CLOG2`, `DATAPATH_W` and `DMEM_SZ` defines.
- **Sub-module `spi_clkgen`:**
  - Divider counter.
  - `sclk` toggle flop.
  - One-cycle `lead_stb`/`trail_stb` outputs.
  - Enabled only in XFER.
- **Top level:** FSM, TX shift register (DATA_W+ADDR_W), RX shift register, bit counter and CS decode.

## Test plan
- **Mode 0, div 0, data only:** DATA_W=8, tx 0xA5, MISO looped to MOSI.
  - 8 sclk rising edges.
  - MOSI 1,0,1,0,0,1,0,1.
  - `rx_data_out`=0xA5.
  - `busy_out` high for 18 cycles; `done_out` once.
- **Mode 3, div 2, addr_en=1, ADDR_W=4:** tx 0x3C, addr 0x9.
  - 12 bits; frame 0x3C9 MSB first.
  - `sclk` idles high; half-period 3 cycles.
  - `busy_out` high for 78 cycles.
- **Modes 1/2, MISO driven by a slave model returning 0x5A:** `rx_data_out`=0x5A. The bench checks that sampling occurs on the correct edge.
- **CS select:** `cs_sel`=1 → `cs_n_out`=2'b01 only during the transfer; `cs_sel`=3 with N_CS=2 → `cs_n_out` stays 2'b11 and `done_out` still pulses.
- **`start_in` held high across `done_out`:** the second transfer begins exactly one cycle after IDLE is re-entered, and its new `tx_data` is latched.
- **Reset low mid-XFER:** next edge gives `cs_n_out` all 1, `sclk_out`=0, `busy_out`=0. No `done_out`.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: state encoding, SPI mode constants and
// default field widths derived from the core's datapath/memory defines.
`ifndef DATAPATH_W
`define DATAPATH_W 8
`endif
`ifndef DMEM_SZ
`define DMEM_SZ 16
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package spi_pkg;

   localparam int DEF_DATA_W = `DATAPATH_W;
   localparam int DEF_ADDR_W = `CLOG2(`DMEM_SZ);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_XFER  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // Mode encoding is {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic logic mode_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK generator: divider counter and toggle flop, producing one-cycle strobes
// coincident with the clk edge on which SCLK makes its leading/trailing transition.
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             idle_lvl,
   input  logic [DIV_W-1:0] div,
   output logic             sclk,
   output logic             lead_stb,
   output logic             trail_stb
);

   logic [DIV_W-1:0] div_cnt;
   logic             half;
   logic             tick;

   assign tick      = en && (div_cnt == '0);
   assign lead_stb  = tick && !half;
   assign trail_stb = tick && half;

   // Outside XFER the counter is preloaded so the first edge lands exactly H cycles in.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
         half    <= 1'b0;
      end else if (!en) begin
         div_cnt <= div;
         sclk    <= idle_lvl;
         half    <= 1'b0;
      end else if (tick) begin
         div_cnt <= div;
         sclk    <= ~sclk;
         half    <= ~half;
      end else begin
         div_cnt <= div_cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// Parametrised SPI master: four CPOL/CPHA modes, programmable SCLK divider,
// one-hot active-low chip selects and full-duplex {data, addr} or data-only frames.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int   DATA_W = DEF_DATA_W,
   parameter int   ADDR_W = DEF_ADDR_W,
   parameter int   N_CS   = 2,
   parameter int   DIV_W  = 4,
   localparam int  CS_W   = (N_CS > 1) ? $clog2(N_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic              addr_en_in,
   input  logic              cpol_in,
   input  logic              cpha_in,
   input  logic [DIV_W-1:0]  clk_div_in,
   input  logic [CS_W-1:0]   cs_sel_in,
   input  logic [DATA_W-1:0] tx_data_in,
   input  logic [ADDR_W-1:0] tx_addr_in,
   input  logic              miso_in,
   output logic              busy_out,
   output logic              done_out,
   output logic [DATA_W-1:0] rx_data_out,
   output logic              sclk_out,
   output logic              mosi_out,
   output logic [N_CS-1:0]   cs_n_out
);

   localparam int FRAME_W = DATA_W + ADDR_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   logic [1:0]         state;
   logic [DIV_W-1:0]   cnt;
   logic [DIV_W-1:0]   div_q;
   logic [CNT_W-1:0]   bit_cnt;
   logic               cpol_q;
   logic               cpha_q;
   logic [FRAME_W-1:0] tx_sr;
   logic [FRAME_W-1:0] frame;
   logic [N_CS-1:0]    cs_dec;
   logic               start_acc;
   logic               in_xfer;
   logic               idle_lvl;
   logic               lead_stb;
   logic               trail_stb;
   logic               shift_stb;
   logic               sample_stb;
   logic               xfer_end;

   assign start_acc  = (state == ST_IDLE) && start_in;
   assign in_xfer    = (state == ST_XFER);
   // SCLK must already sit at the new CPOL during the first SETUP cycle
   assign idle_lvl   = start_acc ? cpol_in : cpol_q;
   assign frame      = addr_en_in ? {tx_data_in, tx_addr_in} : {tx_data_in, {ADDR_W{1'b0}}};
   assign shift_stb  = cpha_q ? lead_stb : trail_stb;
   assign sample_stb = cpha_q ? trail_stb : lead_stb;
   // The frame always ends on a trailing edge; CPHA=0 still has one shift pending there
   assign xfer_end   = trail_stb && (bit_cnt == {{(CNT_W-1){1'b0}}, ~cpha_q});

   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < N_CS; i++) begin
         cs_dec[i] = (32'(cs_sel_in) != i);
      end
   end

   spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
      .clk       (clk),
      .rst       (rst),
      .en        (in_xfer),
      .idle_lvl  (idle_lvl),
      .div       (div_q),
      .sclk      (sclk_out),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb)
   );

   always_ff @(posedge clk) begin
      if (start_acc) begin
         tx_sr <= cpha_in ? frame : (frame << 1);
      end else if (in_xfer && shift_stb) begin
         tx_sr <= tx_sr << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         div_q       <= '0;
         bit_cnt     <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         busy_out    <= 1'b0;
         done_out    <= 1'b0;
         cs_n_out    <= '1;
         mosi_out    <= 1'b0;
         rx_data_out <= '0;
      end else begin
         done_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_in) begin
                  state    <= ST_SETUP;
                  busy_out <= 1'b1;
                  cnt      <= clk_div_in;
                  div_q    <= clk_div_in;
                  cpol_q   <= cpol_in;
                  cpha_q   <= cpha_in;
                  cs_n_out <= cs_dec;
                  bit_cnt  <= addr_en_in ? CNT_W'(FRAME_W) : CNT_W'(DATA_W);
                  if (!cpha_in) mosi_out <= frame[FRAME_W-1];
               end
            end
            ST_SETUP: begin
               if (cnt == '0) state <= ST_XFER;
               else           cnt   <= cnt - DIV_W'(1);
            end
            ST_XFER: begin
               if (shift_stb) begin
                  mosi_out <= tx_sr[FRAME_W-1];
                  if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
               end
               if (sample_stb) rx_data_out <= {rx_data_out[DATA_W-2:0], miso_in};
               if (xfer_end) begin
                  state    <= ST_HOLD;
                  cnt      <= div_q;
                  done_out <= (div_q == '0);
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  state    <= ST_IDLE;
                  busy_out <= 1'b0;
                  cs_n_out <= '1;
               end else begin
                  cnt      <= cnt - DIV_W'(1);
                  done_out <= (cnt == DIV_W'(1));
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: observes SCLK edges, MOSI, CS and
// timing against a frame-level reference model, with loopback or slave MISO.
module tb_spi_master_ctrl;
   import spi_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int N_CS   = 3;
   localparam int DIV_W  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_in = 1'b0;
   logic        addr_en_in = 1'b0;
   logic        cpol_in = 1'b0;
   logic        cpha_in = 1'b0;
   logic [3:0]  clk_div_in = 4'd0;
   logic [1:0]  cs_sel_in = 2'd0;
   logic [7:0]  tx_data_in = 8'd0;
   logic [3:0]  tx_addr_in = 4'd0;
   logic        miso_in;
   logic        busy_out;
   logic        done_out;
   logic [7:0]  rx_data_out;
   logic        sclk_out;
   logic        mosi_out;
   logic [2:0]  cs_n_out;

   logic        loop_mode = 1'b1;
   logic        slave_miso = 1'b0;
   assign miso_in = loop_mode ? mosi_out : slave_miso;

   int total = 0;
   int bad   = 0;

   int ob_busy, ob_done, ob_edges, ob_rise, ob_samples;
   int ob_rxbad, ob_mosibad, ob_csbad, ob_sclkbad, ob_gapbad;
   logic        ob_busy_first, ob_timeout, ob_idle_sclk;
   logic [11:0] ob_bits;
   logic [2:0]  ob_cs_seen;

   spi_master_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CS(N_CS), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .addr_en_in(addr_en_in),
      .cpol_in(cpol_in), .cpha_in(cpha_in), .clk_div_in(clk_div_in), .cs_sel_in(cs_sel_in),
      .tx_data_in(tx_data_in), .tx_addr_in(tx_addr_in), .miso_in(miso_in),
      .busy_out(busy_out), .done_out(done_out), .rx_data_out(rx_data_out),
      .sclk_out(sclk_out), .mosi_out(mosi_out), .cs_n_out(cs_n_out)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Runs one transfer from the current negedge and records what the pins did.
   task automatic run_xfer(input logic [7:0] d, input logic [3:0] a, input logic ae,
                           input logic pol, input logic pha, input logic [3:0] div,
                           input logic [1:0] sel, input logic hold, input logic [11:0] sw);
      int n, s, idx, cyc, last_e;
      logic psclk, pmosi, first, edge_now, smp;
      logic [7:0] prx;
      logic [2:0] ecs;
      n = ae ? 12 : 8;
      ecs = (sel < N_CS) ? ~(3'b001 << sel) : 3'b111;
      ob_busy = 0; ob_done = 0; ob_edges = 0; ob_rise = 0; ob_samples = 0;
      ob_rxbad = 0; ob_mosibad = 0; ob_csbad = 0; ob_sclkbad = 0; ob_gapbad = 0;
      ob_bits = '0; ob_cs_seen = 3'b111; last_e = 0;
      s = 0;
      slave_miso = pha ? 1'b0 : sw[n-1];
      tx_data_in = d; tx_addr_in = a; addr_en_in = ae; cpol_in = pol; cpha_in = pha;
      clk_div_in = div; cs_sel_in = sel; start_in = 1'b1;
      psclk = sclk_out; pmosi = mosi_out; prx = rx_data_out;
      @(negedge clk);
      if (!hold) start_in = 1'b0;
      tx_data_in = 8'($urandom); tx_addr_in = 4'($urandom); addr_en_in = 1'($urandom);
      cpol_in = 1'($urandom); cpha_in = 1'($urandom); clk_div_in = 4'($urandom);
      cs_sel_in = 2'($urandom);
      ob_busy_first = busy_out;
      ob_cs_seen = cs_n_out;
      first = 1'b1;
      for (cyc = 0; cyc < 700; cyc++) begin
         edge_now = !first && (sclk_out !== psclk);
         if (first && sclk_out !== pol) ob_sclkbad++;
         smp = 1'b0;
         if (edge_now) begin
            ob_edges++;
            if (sclk_out === 1'b1) ob_rise++;
            if (ob_edges > 1 && (cyc - last_e) != int'(div) + 1) ob_gapbad++;
            last_e = cyc;
            smp = pha ? (ob_edges % 2 == 0) : (ob_edges % 2 == 1);
         end
         if (rx_data_out !== prx && !(edge_now && smp)) ob_rxbad++;
         if (!first && mosi_out !== pmosi && !(edge_now && !smp)) ob_mosibad++;
         if (edge_now && smp) begin
            ob_samples++;
            ob_bits = {ob_bits[10:0], mosi_out};
         end
         if (edge_now && !smp) begin
            s++;
            idx = pha ? s - 1 : s;
            slave_miso = (idx >= 0 && idx < n) ? sw[n-1-idx] : 1'b0;
         end
         if (busy_out) begin
            ob_busy++;
            if (cs_n_out !== ecs) ob_csbad++;
         end else if (cs_n_out !== 3'b111) ob_csbad++;
         if (done_out) ob_done++;
         if (!busy_out) break;
         psclk = sclk_out; pmosi = mosi_out; prx = rx_data_out; first = 1'b0;
         @(negedge clk);
      end
      ob_timeout = (cyc >= 700);
      ob_idle_sclk = sclk_out;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (cs_n_out !== 3'b111) begin bad++; $display("FAIL reset_cs got=%b exp=111", cs_n_out); end
      total++; if (sclk_out !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk_out); end
      total++; if (mosi_out !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", mosi_out); end
      total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
      total++; if (done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_out); end
      total++; if (rx_data_out !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h exp=00", rx_data_out); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mode0();
      loop_mode = 1'b1;
      run_xfer(8'hA5, 4'h0, 1'b0, mode_cpol(SPI_MODE0), mode_cpha(SPI_MODE0), 4'd0, 2'd0, 1'b0, 12'h000);
      total++; if (ob_timeout) begin bad++; $display("FAIL m0_timeout got=1 exp=0"); end
      total++; if (ob_busy_first !== 1'b1) begin bad++; $display("FAIL m0_busy_rise got=%b exp=1", ob_busy_first); end
      total++; if (ob_rise != 8) begin bad++; $display("FAIL m0_rising got=%0d exp=8", ob_rise); end
      total++; if (ob_bits[7:0] !== 8'hA5) begin bad++; $display("FAIL m0_mosi got=%h exp=a5", ob_bits[7:0]); end
      total++; if (rx_data_out !== 8'hA5) begin bad++; $display("FAIL m0_rx got=%h exp=a5", rx_data_out); end
      total++; if (ob_busy != 18) begin bad++; $display("FAIL m0_busy_len got=%0d exp=18", ob_busy); end
      total++; if (ob_done != 1) begin bad++; $display("FAIL m0_done got=%0d exp=1", ob_done); end
      total++; if (ob_rxbad + ob_mosibad + ob_sclkbad != 0) begin
         bad++; $display("FAIL m0_edges got=%0d/%0d/%0d exp=0/0/0", ob_rxbad, ob_mosibad, ob_sclkbad);
      end
   endtask

   task automatic test_mode3_addr();
      loop_mode = 1'b1;
      run_xfer(8'h3C, 4'h9, 1'b1, mode_cpol(SPI_MODE3), mode_cpha(SPI_MODE3), 4'd2, 2'd0, 1'b0, 12'h000);
      total++; if (ob_samples != 12) begin bad++; $display("FAIL m3_bits got=%0d exp=12", ob_samples); end
      total++; if (ob_bits !== 12'h3C9) begin bad++; $display("FAIL m3_frame got=%h exp=3c9", ob_bits); end
      total++; if (ob_busy != 78) begin bad++; $display("FAIL m3_busy_len got=%0d exp=78", ob_busy); end
      total++; if (ob_gapbad != 0) begin bad++; $display("FAIL m3_half_period got=%0d exp=0", ob_gapbad); end
      total++; if (ob_idle_sclk !== 1'b1 || ob_sclkbad != 0) begin
         bad++; $display("FAIL m3_idle got=%b/%0d exp=1/0", ob_idle_sclk, ob_sclkbad);
      end
      total++; if (rx_data_out !== 8'hC9) begin bad++; $display("FAIL m3_rx got=%h exp=c9", rx_data_out); end
   endtask

   task automatic test_modes12();
      loop_mode = 1'b0;
      run_xfer(8'h00, 4'h0, 1'b0, mode_cpol(SPI_MODE1), mode_cpha(SPI_MODE1), 4'd1, 2'd0, 1'b0, 12'h05A);
      total++; if (rx_data_out !== 8'h5A) begin bad++; $display("FAIL m1_rx got=%h exp=5a", rx_data_out); end
      total++; if (ob_rxbad != 0) begin bad++; $display("FAIL m1_sample_edge got=%0d exp=0", ob_rxbad); end
      total++; if (ob_idle_sclk !== 1'b0) begin bad++; $display("FAIL m1_idle got=%b exp=0", ob_idle_sclk); end
      run_xfer(8'hFF, 4'h0, 1'b0, mode_cpol(SPI_MODE2), mode_cpha(SPI_MODE2), 4'd1, 2'd0, 1'b0, 12'h05A);
      total++; if (rx_data_out !== 8'h5A) begin bad++; $display("FAIL m2_rx got=%h exp=5a", rx_data_out); end
      total++; if (ob_rxbad != 0) begin bad++; $display("FAIL m2_sample_edge got=%0d exp=0", ob_rxbad); end
      total++; if (ob_bits[7:0] !== 8'hFF) begin bad++; $display("FAIL m2_mosi got=%h exp=ff", ob_bits[7:0]); end
      loop_mode = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] d; logic [3:0] a, div; logic ae, pol, pha, lp; logic [1:0] sel;
      logic [11:0] sw, ef, eb; logic [7:0] erx; int n, eb_len;
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom); a = 4'($urandom); ae = 1'($urandom); pol = 1'($urandom);
         pha = 1'($urandom); div = 4'($urandom_range(0, 4)); sel = 2'($urandom_range(0, 3));
         lp = 1'($urandom); sw = 12'($urandom);
         loop_mode = lp;
         run_xfer(d, a, ae, pol, pha, div, sel, 1'b0, sw);
         n = ae ? 12 : 8;
         ef = ae ? {d, a} : {4'h0, d};
         eb = ae ? ob_bits : {4'h0, ob_bits[7:0]};
         erx = lp ? ef[7:0] : sw[7:0];
         eb_len = (int'(div) + 1) * (2 * n + 2);
         total++; if (eb !== ef) begin bad++; $display("FAIL rnd%0d_mosi got=%h exp=%h", i, eb, ef); end
         total++; if (rx_data_out !== erx) begin bad++; $display("FAIL rnd%0d_rx got=%h exp=%h", i, rx_data_out, erx); end
         total++; if (ob_busy != eb_len) begin bad++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", i, ob_busy, eb_len); end
         total++; if (ob_done != 1) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=1", i, ob_done); end
         total++; if (ob_edges != 2 * n) begin bad++; $display("FAIL rnd%0d_edges got=%0d exp=%0d", i, ob_edges, 2 * n); end
         total++; if (ob_idle_sclk !== pol) begin bad++; $display("FAIL rnd%0d_idle got=%b exp=%b", i, ob_idle_sclk, pol); end
         total++; if (ob_rxbad + ob_mosibad + ob_csbad + ob_gapbad + ob_sclkbad != 0) begin
            bad++; $display("FAIL rnd%0d_protocol got=%0d/%0d/%0d/%0d/%0d exp=0", i,
                            ob_rxbad, ob_mosibad, ob_csbad, ob_gapbad, ob_sclkbad);
         end
      end
      loop_mode = 1'b1;
   endtask

   task automatic test_cs();
      loop_mode = 1'b1;
      run_xfer(8'h96, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0, 12'h000);
      total++; if (ob_cs_seen !== 3'b101) begin bad++; $display("FAIL cs1_sel got=%b exp=101", ob_cs_seen); end
      total++; if (ob_csbad != 0) begin bad++; $display("FAIL cs1_window got=%0d exp=0", ob_csbad); end
      total++; if (cs_n_out !== 3'b111) begin bad++; $display("FAIL cs1_release got=%b exp=111", cs_n_out); end
      run_xfer(8'h69, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 1'b0, 12'h000);
      total++; if (ob_cs_seen !== 3'b111 || ob_csbad != 0) begin
         bad++; $display("FAIL cs3_none got=%b/%0d exp=111/0", ob_cs_seen, ob_csbad);
      end
      total++; if (ob_done != 1) begin bad++; $display("FAIL cs3_done got=%0d exp=1", ob_done); end
   endtask

   task automatic test_back_to_back();
      int extra;
      loop_mode = 1'b1;
      run_xfer(8'h81, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 12'h000);
      total++; if (ob_busy != 18 || ob_done != 1) begin
         bad++; $display("FAIL b2b_first got=%0d/%0d exp=18/1", ob_busy, ob_done);
      end
      run_xfer(8'h7E, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 12'h000);
      total++; if (ob_busy_first !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b exp=1", ob_busy_first); end
      total++; if (ob_bits[7:0] !== 8'h7E) begin bad++; $display("FAIL b2b_data got=%h exp=7e", ob_bits[7:0]); end
      extra = 0;
      repeat (10) begin @(negedge clk); extra += int'(busy_out); end
      total++; if (extra != 0) begin bad++; $display("FAIL b2b_no_queue got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_mid();
      int dn, bz;
      loop_mode = 1'b1;
      tx_data_in = 8'hF0; addr_en_in = 1'b0; cpol_in = 1'b0; cpha_in = 1'b0;
      clk_div_in = 4'd0; cs_sel_in = 2'd0; start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      repeat (8) @(negedge clk);
      total++; if (busy_out !== 1'b1 || cs_n_out !== 3'b110) begin
         bad++; $display("FAIL rstmid_active got=%b/%b exp=1/110", busy_out, cs_n_out);
      end
      rst = 1'b0;
      @(negedge clk);
      total++; if (cs_n_out !== 3'b111) begin bad++; $display("FAIL rstmid_cs got=%b exp=111", cs_n_out); end
      total++; if (sclk_out !== 1'b0) begin bad++; $display("FAIL rstmid_sclk got=%b exp=0", sclk_out); end
      total++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin
         bad++; $display("FAIL rstmid_busy got=%b/%b exp=0/0", busy_out, done_out);
      end
      total++; if (rx_data_out !== 8'h00 || mosi_out !== 1'b0) begin
         bad++; $display("FAIL rstmid_data got=%h/%b exp=00/0", rx_data_out, mosi_out);
      end
      rst = 1'b1;
      dn = 0; bz = 0;
      repeat (30) begin @(negedge clk); dn += int'(done_out); bz += int'(busy_out); end
      total++; if (dn != 0 || bz != 0) begin bad++; $display("FAIL rstmid_after got=%0d/%0d exp=0/0", dn, bz); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3_addr();
      test_modes12();
      test_cs();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
